src_datapath: RTL and testbench
===============================

// Module: src_datapath
// PURPOSE
// - 32-bit Mini-SRC CPU datapath: R0-R15, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, In/Out ports, CON FF, ALU, 512x32 RAM, single shared bus.
// - Every control strobe is driven externally by the control unit or a bench; the block holds no sequencer.
// - Register instances are named PC, R0..R15; each exposes its 32-bit value on a signal named BusMuxIn, so benches can preload them hierarchically.
// PARAMETERS
// - MEM_DEPTH  512  RAM words; MAR[8:0] addresses the RAM.
// PORTS
// - clock  in  1  single clock; all state updates on posedge.
// - clear  in  1  synchronous, active-high reset.
// - PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout  in  1  bus-source selects; Rout/BAout select R[ra|rb|rc].
// - Rout, BAout  in  1  drive selected GPR; under BAout, R0 reads as 0.
// - Gra, Grb, Grc  in  1  choose IR ra[26:23] / rb[22:19] / rc[18:15] for Rin/Rout/BAout.
// - PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin, Cin  in  1  register load enables (Cin unused, reserved).
// - Rin  in  1  load bus into decoded GPR.
// - InPortin  in  1  latch InPort_input; OutPortin  in  1  latch bus into OutPort.
// - IncPC  in  1  with PCin, PC <= PC+1.
// - Read  in  1  MDR source = RAM[MAR] (else bus); Write  in  1  RAM[MAR] <= MDR.
// - CONin  in  1  latch branch condition into CON.
// - JAL_flag  in  1  R15 <= bus (link write).
// - InPort_input  in  32  external input data.
// - OutPort_out  out  32  OutPort register.
// - CON_out  out  1  CON flip-flop.
// BEHAVIOUR
// - clear=1 at posedge: every register (PC, GPRs, IR, MAR, MDR, Y, Z, HI, LO, ports, CON) <= 0; RAM keeps contents.
// - clear has priority over all enables; OutPort_out and CON_out read 0 the cycle after clear.
// - Bus is combinational; one source is asserted at a time.
// - Source priority if several: PCout > MDRout > Zhighout > Zlowout > HIout > LOout > InPortout > Cout > Rout/BAout. No source: bus = 0.
// - Cout drives sign-extended IR[18:0].
// - Register load: posedge with enable high -> reg <= bus. Latency is 1 clock.
// - PC: IncPC&PCin -> PC+1, else PCin -> bus. IncPC alone does nothing.
// - RAM: combinational read of RAM[MAR[8:0]]; synchronous write.
// - MDRin&Read -> MDR <= RAM[MAR]. Write and Read together: the write happens, MDR gets the old word.
// - Z: Zlowin loads Z[31:0] from ALU low; Zhighin loads Z[63:32] from ALU high.
// - ALU A = Y, B = bus; op = IR[31:27].
//   ld/ldi/st/addi/br = A+B; add 00011; sub 00100 (A-B); and/andi; or/ori.
//   shr, shra, shl, ror, rol: A by B[4:0].
//   mul 01111: 64-bit signed product, {HI,LO} = {Zhigh,Zlow}.
//   div 10000: Zlow = quotient, Zhigh = remainder; B=0 gives Z=0.
//   neg 10001 = -B; not 10010 = ~B.
//   jal 10101, jr 10100 and all others: Zlow = B pass-through, Zhigh = 0.
// - CON: CONin latches on bus value vs IR[20:19]:
//   00 ==0, 01 !=0, 10 >=0 (bit31 clear), 11 <0.
// - JAL_flag: R15 <= bus. If Rin targets a different GPR in the same cycle, both load. If Rin also targets R15, R15 gets the bus either way.
// - GPR writes to R0 are allowed; only BAout masks R0.
// TESTING
// - jal: PC=14, RAM[14]=0xAB000000 (jal ra=R6), R6=28.
//   Run T0(PCout,MARin,IncPC,PCin), T1(Read,MDRin), T2(MDRout,IRin), T3(PCout,Zlowin), T4(Zlowout,JAL_flag), T5(Gra,Rout,PCin).
//   Expect MAR=14, PC=15, IR=0xAB000000, Z=15, R15=15, final PC=28.
// - add: R2=5, R3=6, IR=add R1,R2,R3; Y<=R2, Zlowin with Rout R3, Zlowout->R1 -> R1=11.
// - mul/div: Y=-6, B=4 -> mul gives HI=0xFFFFFFFF, LO=0xFFFFFFE8.
//   Y=7, B=2 -> div gives LO=3, HI=1. B=0 -> Z=0.
// - brzr/brmi: R5=0, C2=00, CONin -> CON=1. R5=0x80000000, C2=11 -> CON=1. R5=1, C2=11 -> CON=0.
// - memory: st R4=0x55 at MAR=0x40, then ld -> MDR=0x55.
//   BAout with ra=R0 holding 9 -> bus=0.
// - clear mid-run: assert clear one cycle -> PC, R15, Z, CON, OutPort all 0; RAM unchanged.

Source files
------------

// File: rtl/src_datapath.sv
// Mini-SRC 32-bit datapath: GPR file, PC/IR/MAR/MDR/Y/Z/HI/LO, I/O ports, CON flag,
// ALU and word RAM around one shared bus. Every strobe is driven by an external control unit.

module src_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] BusMuxIn
);

  always_ff @(posedge clock) begin
    if (clear)     BusMuxIn <= '0;
    else if (en_i) BusMuxIn <= d_i;
  end

endmodule

module src_datapath #(
  parameter int MEM_DEPTH = 512
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        InPortout,
  input  logic        Cout,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        Zhighin,
  input  logic        Zlowin,
  input  logic        Cin,
  input  logic        Rin,
  input  logic        InPortin,
  input  logic        OutPortin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic        CONin,
  input  logic        JAL_flag,
  input  logic [31:0] InPort_input,
  output logic [31:0] OutPort_out,
  output logic        CON_out
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010, OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100, OP_SHR  = 5'b00101, OP_SHRA = 5'b00110, OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000, OP_ROL  = 5'b01001, OP_AND  = 5'b01010, OP_OR   = 5'b01011,
    OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110, OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000, OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_BR   = 5'b10011
  } op_e;

  logic [31:0] bus;
  logic [31:0] pcVal;
  logic [31:0] pc_d;
  logic [31:0] gprVal [16];
  logic [15:0] gprEn;
  logic [31:0] gprOut;
  logic [3:0]  regSel;
  logic        selValid;

  logic [31:0] ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, zHi_q, zLo_q, inPort_q, outPort_q;
  logic [31:0] mdr_d;
  logic        con_q, con_d;

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] ramRd;

  op_e                op;
  logic [4:0]         shamt;
  logic [63:0]        prodFull;
  logic [63:0]        rotL, rotR;
  logic [31:0]        divisor;
  logic signed [31:0] quot, rem;
  logic [31:0]        aluLo, aluHi;

  // Gra > Grb > Grc; with none asserted no GPR is addressed by Rin/Rout/BAout.
  always_comb begin
    regSel   = 4'd0;
    selValid = 1'b1;
    if (Gra)      regSel = ir_q[26:23];
    else if (Grb) regSel = ir_q[22:19];
    else if (Grc) regSel = ir_q[18:15];
    else          selValid = 1'b0;
  end

  always_comb begin
    gprEn = '0;
    if (Rin && selValid) gprEn[regSel] = 1'b1;
    if (JAL_flag)        gprEn[15]     = 1'b1;
  end

  assign gprOut = (BAout && !Rout && regSel == 4'd0) ? 32'd0 : gprVal[regSel];

  always_comb begin
    bus = 32'd0;
    if (PCout)                             bus = pcVal;
    else if (MDRout)                       bus = mdr_q;
    else if (Zhighout)                     bus = zHi_q;
    else if (Zlowout)                      bus = zLo_q;
    else if (HIout)                        bus = hi_q;
    else if (LOout)                        bus = lo_q;
    else if (InPortout)                    bus = inPort_q;
    else if (Cout)                         bus = {{13{ir_q[18]}}, ir_q[18:0]};
    else if ((Rout || BAout) && selValid)  bus = gprOut;
  end

  assign pc_d = IncPC ? pcVal + 32'd1 : bus;

  src_reg PC  (.clock, .clear, .en_i(PCin),      .d_i(pc_d), .BusMuxIn(pcVal));
  src_reg R0  (.clock, .clear, .en_i(gprEn[0]),  .d_i(bus),  .BusMuxIn(gprVal[0]));
  src_reg R1  (.clock, .clear, .en_i(gprEn[1]),  .d_i(bus),  .BusMuxIn(gprVal[1]));
  src_reg R2  (.clock, .clear, .en_i(gprEn[2]),  .d_i(bus),  .BusMuxIn(gprVal[2]));
  src_reg R3  (.clock, .clear, .en_i(gprEn[3]),  .d_i(bus),  .BusMuxIn(gprVal[3]));
  src_reg R4  (.clock, .clear, .en_i(gprEn[4]),  .d_i(bus),  .BusMuxIn(gprVal[4]));
  src_reg R5  (.clock, .clear, .en_i(gprEn[5]),  .d_i(bus),  .BusMuxIn(gprVal[5]));
  src_reg R6  (.clock, .clear, .en_i(gprEn[6]),  .d_i(bus),  .BusMuxIn(gprVal[6]));
  src_reg R7  (.clock, .clear, .en_i(gprEn[7]),  .d_i(bus),  .BusMuxIn(gprVal[7]));
  src_reg R8  (.clock, .clear, .en_i(gprEn[8]),  .d_i(bus),  .BusMuxIn(gprVal[8]));
  src_reg R9  (.clock, .clear, .en_i(gprEn[9]),  .d_i(bus),  .BusMuxIn(gprVal[9]));
  src_reg R10 (.clock, .clear, .en_i(gprEn[10]), .d_i(bus),  .BusMuxIn(gprVal[10]));
  src_reg R11 (.clock, .clear, .en_i(gprEn[11]), .d_i(bus),  .BusMuxIn(gprVal[11]));
  src_reg R12 (.clock, .clear, .en_i(gprEn[12]), .d_i(bus),  .BusMuxIn(gprVal[12]));
  src_reg R13 (.clock, .clear, .en_i(gprEn[13]), .d_i(bus),  .BusMuxIn(gprVal[13]));
  src_reg R14 (.clock, .clear, .en_i(gprEn[14]), .d_i(bus),  .BusMuxIn(gprVal[14]));
  src_reg R15 (.clock, .clear, .en_i(gprEn[15]), .d_i(bus),  .BusMuxIn(gprVal[15]));

  assign op       = op_e'(ir_q[31:27]);
  assign shamt    = bus[4:0];
  assign prodFull = {{32{y_q[31]}}, y_q} * {{32{bus[31]}}, bus};
  assign rotL     = {y_q, y_q} << shamt;
  assign rotR     = {y_q, y_q} >> shamt;
  assign divisor  = (bus == 32'd0) ? 32'd1 : bus;
  assign quot     = $signed(y_q) / $signed(divisor);
  assign rem      = $signed(y_q) % $signed(divisor);

  // Anything not decoded here (jr, jal, in, out, mfhi, ...) passes B straight through.
  always_comb begin
    aluLo = bus;
    aluHi = 32'd0;
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BR: aluLo = y_q + bus;
      OP_SUB:          aluLo = y_q - bus;
      OP_AND, OP_ANDI: aluLo = y_q & bus;
      OP_OR, OP_ORI:   aluLo = y_q | bus;
      OP_SHR:          aluLo = y_q >> shamt;
      OP_SHRA:         aluLo = $signed(y_q) >>> shamt;
      OP_SHL:          aluLo = y_q << shamt;
      OP_ROR:          aluLo = rotR[31:0];
      OP_ROL:          aluLo = rotL[63:32];
      OP_MUL: begin
        aluLo = prodFull[31:0];
        aluHi = prodFull[63:32];
      end
      OP_DIV: begin
        aluLo = (bus == 32'd0) ? 32'd0 : quot;
        aluHi = (bus == 32'd0) ? 32'd0 : rem;
      end
      OP_NEG:          aluLo = 32'd0 - bus;
      OP_NOT:          aluLo = ~bus;
      default:         aluLo = bus;
    endcase
  end

  always_comb begin
    case (ir_q[20:19])
      2'b00:   con_d = (bus == 32'd0);
      2'b01:   con_d = (bus != 32'd0);
      2'b10:   con_d = !bus[31];
      default: con_d = bus[31];
    endcase
  end

  assign ramRd = mem[mar_q[AW-1:0]];
  assign mdr_d = Read ? ramRd : bus;

  // RAM is deliberately left out of clear so program/data survive a reset.
  always_ff @(posedge clock) begin
    if (Write) mem[mar_q[AW-1:0]] <= mdr_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      zHi_q     <= '0;
      zLo_q     <= '0;
      inPort_q  <= '0;
      outPort_q <= '0;
      con_q     <= 1'b0;
    end else begin
      if (IRin)      ir_q      <= bus;
      if (MARin)     mar_q     <= bus;
      if (MDRin)     mdr_q     <= mdr_d;
      if (Yin)       y_q       <= bus;
      if (HIin)      hi_q      <= bus;
      if (LOin)      lo_q      <= bus;
      if (Zhighin)   zHi_q     <= aluHi;
      if (Zlowin)    zLo_q     <= aluLo;
      if (InPortin)  inPort_q  <= InPort_input;
      if (OutPortin) outPort_q <= bus;
      if (CONin)     con_q     <= con_d;
    end
  end

  assign OutPort_out = outPort_q;
  assign CON_out     = con_q;

  logic unusedBits;
  assign unusedBits = ^{Cin, mar_q[31:AW], rotL[31:0], rotR[63:32]};

endmodule

// File: tb/tb_src_datapath.sv
// Self-checking bench for src_datapath: ALU and CON vector tables plus hand-written
// control sequences (jal, add, memory, priority, clear), checked through a scoreboard queue.

module tb_src_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout;
  logic        Rout, BAout, Gra, Grb, Grc;
  logic        PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin, Cin, Rin;
  logic        InPortin, OutPortin, IncPC, Read, Write, CONin, JAL_flag;
  logic [31:0] InPort_input;
  logic [31:0] OutPort_out;
  logic        CON_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
  } aluVec_t;

  typedef struct {
    string       name;
    logic [31:0] val;
    logic [1:0]  c2;
    logic        expCon;
  } conVec_t;

  exp_t sbQ [$];

  src_datapath #(.MEM_DEPTH(512)) dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .Rout(Rout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin), .Cin(Cin),
    .Rin(Rin), .InPortin(InPortin), .OutPortin(OutPortin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .CONin(CONin), .JAL_flag(JAL_flag),
    .InPort_input(InPort_input), .OutPort_out(OutPort_out), .CON_out(CON_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    PCout = 0; Zhighout = 0; Zlowout = 0; MDRout = 0; HIout = 0; LOout = 0;
    InPortout = 0; Cout = 0; Rout = 0; BAout = 0; Gra = 0; Grb = 0; Grc = 0;
    PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Yin = 0; HIin = 0; LOin = 0;
    Zhighin = 0; Zlowin = 0; Cin = 0; Rin = 0; InPortin = 0; OutPortin = 0;
    IncPC = 0; Read = 0; Write = 0; CONin = 0; JAL_flag = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expectPush(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sbQ.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] act);
    exp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty: got 0x%08h, expected a queued value", act);
    end else begin
      e = sbQ.pop_front();
      checkOutput(e.name, act, e.val);
    end
  endtask

  // Latch a value into InPort and leave InPortout asserted so the caller can pick a destination.
  task automatic driveIn(input logic [31:0] v);
    InPort_input = v;
    InPortin = 1;
    tick();
    idle();
    InPortout = 1;
  endtask

  task automatic loadIR(input logic [31:0] v);
    driveIn(v); IRin = 1; tick(); idle();
  endtask

  task automatic setY(input logic [31:0] v);
    driveIn(v); Yin = 1; tick(); idle();
  endtask

  task automatic setGpr(input logic [3:0] idx, input logic [31:0] v);
    loadIR({5'b00000, idx, 23'd0});
    driveIn(v); Gra = 1; Rin = 1; tick(); idle();
  endtask

  task automatic applyStimulus(input aluVec_t v);
    setY(v.a);
    loadIR({v.op, 27'd0});
    driveIn(v.b); Zlowin = 1; Zhighin = 1;
    expectPush({v.name, "_lo"}, v.expLo);
    expectPush({v.name, "_hi"}, v.expHi);
    tick(); idle();
    Zlowout = 1; OutPortin = 1; tick(); idle();
    popCheck(OutPort_out);
    Zhighout = 1; OutPortin = 1; tick(); idle();
    popCheck(OutPort_out);
  endtask

  initial begin
    aluVec_t     aluVecs [23];
    conVec_t     conVecs [7];
    logic [31:0] irWord;

    aluVecs[0]  = '{"add",    5'b00011, 32'd5,         32'd6,         32'd11,        32'd0};
    aluVecs[1]  = '{"sub",    5'b00100, 32'd3,         32'd5,         32'hFFFF_FFFE, 32'd0};
    aluVecs[2]  = '{"and",    5'b01010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'd0};
    aluVecs[3]  = '{"or",     5'b01011, 32'hF000_000F, 32'h0000_0F00, 32'hF000_0F0F, 32'd0};
    aluVecs[4]  = '{"shr",    5'b00101, 32'h8000_0010, 32'd4,         32'h0800_0001, 32'd0};
    aluVecs[5]  = '{"shra",   5'b00110, 32'h8000_0010, 32'd4,         32'hF800_0001, 32'd0};
    aluVecs[6]  = '{"shl",    5'b00111, 32'd3,         32'd31,        32'h8000_0000, 32'd0};
    aluVecs[7]  = '{"ror",    5'b01000, 32'd1,         32'd1,         32'h8000_0000, 32'd0};
    aluVecs[8]  = '{"ror32",  5'b01000, 32'h1234_5678, 32'h20,        32'h1234_5678, 32'd0};
    aluVecs[9]  = '{"rol",    5'b01001, 32'h8000_0001, 32'd4,         32'h0000_0018, 32'd0};
    aluVecs[10] = '{"mul",    5'b01111, 32'hFFFF_FFFA, 32'd4,         32'hFFFF_FFE8, 32'hFFFF_FFFF};
    aluVecs[11] = '{"mulbig", 5'b01111, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1};
    aluVecs[12] = '{"div",    5'b10000, 32'd7,         32'd2,         32'd3,         32'd1};
    aluVecs[13] = '{"div0",   5'b10000, 32'd7,         32'd0,         32'd0,         32'd0};
    aluVecs[14] = '{"neg",    5'b10001, 32'h1234,      32'd5,         32'hFFFF_FFFB, 32'd0};
    aluVecs[15] = '{"not",    5'b10010, 32'd0,         32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'd0};
    aluVecs[16] = '{"jal",    5'b10101, 32'hDEAD,      32'h1234,      32'h1234,      32'd0};
    aluVecs[17] = '{"ld",     5'b00000, 32'h100,       32'h23,        32'h123,       32'd0};
    aluVecs[18] = '{"addi",   5'b01100, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0};
    aluVecs[19] = '{"andi",   5'b01101, 32'hFF,        32'h0F,        32'h0F,        32'd0};
    aluVecs[20] = '{"ori",    5'b01110, 32'hF0,        32'h0F,        32'hFF,        32'd0};
    aluVecs[21] = '{"shra_b", 5'b00110, 32'h4000_0000, 32'h21,        32'h2000_0000, 32'd0};
    aluVecs[22] = '{"mulneg", 5'b01111, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15,        32'd0};

    conVecs[0] = '{"con_zr_0",   32'd0,         2'b00, 1'b1};
    conVecs[1] = '{"con_mi_neg", 32'h8000_0000, 2'b11, 1'b1};
    conVecs[2] = '{"con_mi_pos", 32'd1,         2'b11, 1'b0};
    conVecs[3] = '{"con_nz_1",   32'd1,         2'b01, 1'b1};
    conVecs[4] = '{"con_nz_0",   32'd0,         2'b01, 1'b0};
    conVecs[5] = '{"con_pl_max", 32'h7FFF_FFFF, 2'b10, 1'b1};
    conVecs[6] = '{"con_pl_neg", 32'h8000_0000, 2'b10, 1'b0};

    idle();
    InPort_input = 32'd0;
    clear = 1;
    tick();
    tick();
    checkOutput("reset_outport", OutPort_out, 32'd0);
    checkOutput("reset_con", {31'd0, CON_out}, 32'd0);
    checkOutput("reset_pc", dut.PC.BusMuxIn, 32'd0);
    clear = 0;

    for (int i = 0; i < 23; i++) applyStimulus(aluVecs[i]);

    // jal fetch/execute: RAM[14] = jal R6, R6 = 28, PC = 14
    driveIn(32'd14); MARin = 1; tick(); idle();
    driveIn(32'hAB00_0000); MDRin = 1; tick(); idle();
    Write = 1; tick(); idle();
    setGpr(4'd6, 32'd28);
    driveIn(32'd14); PCin = 1; tick(); idle();
    PCout = 1; MARin = 1; IncPC = 1; PCin = 1;
    expectPush("jal_t0_mar", 32'd14); expectPush("jal_t0_pc", 32'd15);
    tick(); idle();
    popCheck(dut.mar_q); popCheck(dut.PC.BusMuxIn);
    Read = 1; MDRin = 1; expectPush("jal_t1_mdr", 32'hAB00_0000); tick(); idle();
    popCheck(dut.mdr_q);
    MDRout = 1; IRin = 1; expectPush("jal_t2_ir", 32'hAB00_0000); tick(); idle();
    popCheck(dut.ir_q);
    PCout = 1; Zlowin = 1; expectPush("jal_t3_z", 32'd15); tick(); idle();
    popCheck(dut.zLo_q);
    Zlowout = 1; JAL_flag = 1; expectPush("jal_t4_r15", 32'd15); tick(); idle();
    popCheck(dut.R15.BusMuxIn);
    Gra = 1; Rout = 1; PCin = 1; expectPush("jal_t5_pc", 32'd28); tick(); idle();
    popCheck(dut.PC.BusMuxIn);

    // add R1, R2, R3
    setGpr(4'd2, 32'd5);
    setGpr(4'd3, 32'd6);
    loadIR({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0});
    Grb = 1; Rout = 1; Yin = 1; tick(); idle();
    Grc = 1; Rout = 1; Zlowin = 1; tick(); idle();
    Zlowout = 1; Gra = 1; Rin = 1; expectPush("add_r1", 32'd11); tick(); idle();
    popCheck(dut.R1.BusMuxIn);
    Gra = 1; Rout = 1; OutPortin = 1; expectPush("add_r1_out", 32'd11); tick(); idle();
    popCheck(OutPort_out);

    // mul result moved into HI/LO
    setY(32'hFFFF_FFFA);
    loadIR({5'b01111, 27'd0});
    driveIn(32'd4); Zlowin = 1; Zhighin = 1; tick(); idle();
    Zhighout = 1; HIin = 1; tick(); idle();
    Zlowout = 1; LOin = 1; tick(); idle();
    HIout = 1; OutPortin = 1; expectPush("mul_hi", 32'hFFFF_FFFF); tick(); idle();
    popCheck(OutPort_out);
    LOout = 1; OutPortin = 1; expectPush("mul_lo", 32'hFFFF_FFE8); tick(); idle();
    popCheck(OutPort_out);

    for (int i = 0; i < 7; i++) begin
      setGpr(4'd5, conVecs[i].val);
      irWord = {5'b10011, 4'd5, 23'd0};
      irWord[20:19] = conVecs[i].c2;
      loadIR(irWord);
      Gra = 1; Rout = 1; CONin = 1;
      expectPush(conVecs[i].name, {31'd0, conVecs[i].expCon});
      tick(); idle();
      popCheck({31'd0, CON_out});
    end

    // st R4 -> RAM[0x40], then ld back
    setGpr(4'd4, 32'h55);
    driveIn(32'h40); MARin = 1; tick(); idle();
    loadIR({5'b00010, 4'd4, 23'd0});
    Gra = 1; Rout = 1; MDRin = 1; tick(); idle();
    Write = 1; tick(); idle();
    driveIn(32'd0); MDRin = 1; tick(); idle();
    Read = 1; MDRin = 1; tick(); idle();
    MDRout = 1; OutPortin = 1; expectPush("ld_mdr", 32'h55); tick(); idle();
    popCheck(OutPort_out);
    checkOutput("st_ram40", dut.mem[64], 32'h55);

    // Read and Write in the same cycle: MDR sees the old word
    driveIn(32'h41); MARin = 1; tick(); idle();
    driveIn(32'hAAAA); MDRin = 1; tick(); idle();
    Write = 1; tick(); idle();
    driveIn(32'hBBBB); MDRin = 1; tick(); idle();
    Read = 1; Write = 1; MDRin = 1; expectPush("rw_mdr_old", 32'hAAAA); tick(); idle();
    popCheck(dut.mdr_q);
    checkOutput("rw_ram_new", dut.mem[65], 32'hBBBB);

    setGpr(4'd0, 32'd9);
    Gra = 1; BAout = 1; OutPortin = 1; expectPush("baout_r0", 32'd0); tick(); idle();
    popCheck(OutPort_out);
    Gra = 1; Rout = 1; OutPortin = 1; expectPush("rout_r0", 32'd9); tick(); idle();
    popCheck(OutPort_out);
    loadIR({5'b00000, 4'd6, 23'd0});
    Gra = 1; BAout = 1; OutPortin = 1; expectPush("baout_r6", 32'd28); tick(); idle();
    popCheck(OutPort_out);

    // bus source priority
    driveIn(32'h300); PCin = 1; tick(); idle();
    driveIn(32'h300); PCout = 1; MDRout = 1; OutPortin = 1;
    expectPush("prio_pc_mdr", 32'h300); tick(); idle();
    popCheck(OutPort_out);
    MDRout = 1; InPortout = 1; Zlowout = 1; OutPortin = 1;
    expectPush("prio_mdr_z", 32'hAAAA); tick(); idle();
    popCheck(OutPort_out);
    OutPortin = 1; expectPush("no_source", 32'd0); tick(); idle();
    popCheck(OutPort_out);
    loadIR(32'h0004_0000);
    Cout = 1; Gra = 1; Rout = 1; OutPortin = 1;
    expectPush("cout_sext", 32'hFFFC_0000); tick(); idle();
    popCheck(OutPort_out);
    loadIR(32'h0000_1234);
    Cout = 1; OutPortin = 1; expectPush("cout_pos", 32'h1234); tick(); idle();
    popCheck(OutPort_out);

    IncPC = 1; tick(); idle();
    checkOutput("incpc_alone", dut.PC.BusMuxIn, 32'h300);

    loadIR({5'b10101, 4'd3, 23'd0});
    driveIn(32'h77); Gra = 1; Rin = 1; JAL_flag = 1; tick(); idle();
    checkOutput("jal_rin_r3", dut.R3.BusMuxIn, 32'h77);
    checkOutput("jal_rin_r15", dut.R15.BusMuxIn, 32'h77);

    // make state nonzero, then clear with enables still active
    setY(32'd1);
    loadIR({5'b00011, 27'd0});
    driveIn(32'd2); Zlowin = 1; tick(); idle();
    setGpr(4'd5, 32'd0);
    loadIR({5'b10011, 4'd5, 23'd0});
    Gra = 1; Rout = 1; CONin = 1; tick(); idle();
    driveIn(32'h99); OutPortin = 1; tick(); idle();
    checkOutput("pre_clear_outport", OutPort_out, 32'h99);
    checkOutput("pre_clear_z", dut.zLo_q, 32'd3);
    clear = 1; InPortout = 1; OutPortin = 1; PCin = 1; CONin = 1;
    tick(); idle();
    clear = 0;
    checkOutput("clear_pc", dut.PC.BusMuxIn, 32'd0);
    checkOutput("clear_r15", dut.R15.BusMuxIn, 32'd0);
    checkOutput("clear_z", dut.zLo_q, 32'd0);
    checkOutput("clear_con", {31'd0, CON_out}, 32'd0);
    checkOutput("clear_outport", OutPort_out, 32'd0);
    checkOutput("clear_ram_kept", dut.mem[64], 32'h55);

    checkOutput("scoreboard_drained", sbQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
